// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer: FSM encoding,
// arbitration-mode constants and a constant-evaluable clog2.
package mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational winner selection: round-robin scan upward from ptr with
// wrap-around, or fixed priority where the lowest index wins.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N        = 4,
  parameter int ARB_MODE = ARB_RR,
  localparam int PW      = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_any
);

  // cand_idx[k] is the channel examined k-th in priority order.
  logic [PW-1:0] cand_idx [N];

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_cand
    if (ARB_MODE == ARB_FIXED) begin : g_fixed
      assign cand_idx[gi] = PW'(gi);
    end else begin : g_rr
      logic [PW:0] sum;
      assign sum          = {1'b0, ptr} + (PW+1)'(gi);
      assign cand_idx[gi] = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : sum[PW-1:0];
    end
  end

  if (ARB_MODE == ARB_FIXED) begin : g_ptr_unused
    logic ptr_unused;
    assign ptr_unused = ^ptr;
  end

  // Scanning from the back lets the earliest candidate overwrite later ones.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        gnt_idx = cand_idx[k];
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 packet-aware stream multiplexer: a channel keeps the output locked
// until its last beat, with a single registered output stage.
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter int W        = 8,
  parameter int N        = 4,
  parameter int ARB_MODE = ARB_RR,
  localparam int CW      = clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  output logic           out_last,
  input  logic           out_ready,
  output logic [CW-1:0]  out_chan
);

  state_t        state_reg;
  logic [CW-1:0] ptr_reg;
  logic [CW-1:0] grant_reg;
  logic          out_valid_reg;
  logic          out_last_reg;
  logic [W-1:0]  out_data_reg;
  logic [CW-1:0] out_chan_reg;

  logic [W-1:0]  chan_data [N];
  logic [CW-1:0] arb_idx;
  logic          arb_any;
  logic [CW-1:0] sel_idx;
  logic          sel_valid;
  logic          sel_last;
  logic          load_en;
  logic          accept;
  logic [CW-1:0] ptr_next;

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_chan
    assign chan_data[gi] = in_data[gi*W +: W];
    assign in_ready[gi]  = accept && (sel_idx == CW'(gi));
  end

  rr_arbiter #(
    .N        (N),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_reg),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  // While locked, the arbiter result is ignored and only the owner is served.
  always_comb begin
    sel_idx   = arb_idx;
    sel_valid = arb_any;
    if (state_reg == LOCKED) begin
      sel_idx   = grant_reg;
      sel_valid = in_valid[grant_reg];
    end
  end

  assign load_en  = !out_valid_reg || out_ready;
  assign accept   = sel_valid && load_en && !rst;
  assign sel_last = in_last[sel_idx];
  assign ptr_next = (sel_idx == CW'(N - 1)) ? '0 : sel_idx + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      grant_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
    end else begin
      if (load_en) begin
        out_valid_reg <= accept;
        if (accept) begin
          out_data_reg <= chan_data[sel_idx];
          out_last_reg <= sel_last;
          out_chan_reg <= sel_idx;
        end
      end
      if (accept) begin
        case (state_reg)
          IDLE: begin
            if (sel_last) begin
              ptr_reg <= ptr_next;
            end else begin
              state_reg <= LOCKED;
              grant_reg <= sel_idx;
            end
          end
          LOCKED: begin
            if (sel_last) begin
              state_reg <= IDLE;
              ptr_reg   <= ptr_next;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign out_chan  = out_chan_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: vector table, directed corner sequences and a
// randomized run, all cross-checked against a packet-level reference model.
module tb_stream_mux_rr;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic           out_ready;

  logic [N-1:0]   in_ready0, in_ready1;
  logic [W-1:0]   out_data0, out_data1;
  logic           out_valid0, out_valid1;
  logic           out_last0, out_last1;
  logic [1:0]     out_chan0, out_chan1;

  stream_mux_rr #(.W(W), .N(N), .ARB_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
    .out_last(out_last0), .out_ready(out_ready), .out_chan(out_chan0)
  );

  stream_mux_rr #(.W(W), .N(N), .ARB_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
    .out_last(out_last1), .out_ready(out_ready), .out_chan(out_chan1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for the round-robin instance: who owns the output
  // (if anyone), where the next search starts, and what sits in the output stage.
  bit           m_locked;
  int           m_grant;
  int           m_ptr;
  bit           m_ov;
  bit           m_ol;
  logic [W-1:0] m_od;
  int           m_oc;
  logic [N-1:0] m_ready;

  task automatic model_comb();
    bit load;
    int w;
    m_ready = '0;
    load    = !m_ov || out_ready;
    if (rst) return;
    if (!m_locked) begin
      w = -1;
      for (int k = N - 1; k >= 0; k--)
        if (in_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) m_ready[w] = load;
    end else if (in_valid[m_grant]) begin
      m_ready[m_grant] = load;
    end
  endtask

  task automatic model_edge();
    bit load;
    int hit;
    if (rst) begin
      m_locked = 0; m_grant = 0; m_ptr = 0;
      m_ov = 0; m_ol = 0; m_od = '0; m_oc = 0;
      return;
    end
    load = !m_ov || out_ready;
    hit  = -1;
    for (int c = 0; c < N; c++)
      if (m_ready[c] && in_valid[c]) hit = c;
    if (load) m_ov = (hit >= 0);
    if (hit >= 0) begin
      m_od = in_data[hit*W +: W];
      m_ol = in_last[hit];
      m_oc = hit;
      if (in_last[hit]) begin
        m_locked = 0;
        m_ptr    = (hit + 1) % N;
      end else begin
        m_locked = 1;
        m_grant  = hit;
      end
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                       input logic ordy, input logic r);
    in_valid  = v;
    in_last   = l;
    in_data   = d;
    out_ready = ordy;
    rst       = r;
    #1;
    model_comb();
    check("model in_ready", in_ready0, m_ready);
    check("in_ready onehot", 32'($countones(in_ready0) <= 1), 1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model out_valid", out_valid0, m_ov);
    if (m_ov) begin
      check("model out_data", out_data0, m_od);
      check("model out_last", out_last0, m_ol);
      check("model out_chan", out_chan0, m_oc);
    end
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_ready;
    logic        exp_ov;
    logic [7:0]  exp_od;
    logic [1:0]  exp_oc;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Single-beat round robin, then a locked 3-beat packet, then output hold.
    vecs[0]  = '{4'hF, 4'hF, 32'h44332211, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    vecs[1]  = '{4'hF, 4'hF, 32'h44332211, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    vecs[2]  = '{4'hF, 4'hF, 32'h44332211, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
    vecs[3]  = '{4'hF, 4'hF, 32'h44332211, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    vecs[4]  = '{4'hF, 4'hF, 32'h44332211, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    vecs[5]  = '{4'b0110, 4'b0100, 32'h00C21100, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[6]  = '{4'b0110, 4'b0100, 32'h00C21200, 1'b1, 4'b0010, 1'b1, 8'h12, 2'd1};
    vecs[7]  = '{4'b0110, 4'b0110, 32'h00C21300, 1'b1, 4'b0010, 1'b1, 8'h13, 2'd1};
    vecs[8]  = '{4'b0100, 4'b0100, 32'h00C20000, 1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2};
    vecs[9]  = '{4'b0001, 4'b0001, 32'h000000A5, 1'b1, 4'b0001, 1'b1, 8'hA5, 2'd0};
    vecs[10] = '{4'b0001, 4'b0001, 32'h0000005A, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0};
    vecs[11] = '{4'b0001, 4'b0001, 32'h0000005A, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0};
    vecs[12] = '{4'b0001, 4'b0001, 32'h0000005A, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0};
    vecs[13] = '{4'b0001, 4'b0001, 32'h0000005A, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0};
    vecs[14] = '{4'b0001, 4'b0001, 32'h0000005A, 1'b1, 4'b0001, 1'b1, 8'h5A, 2'd0};
    vecs[15] = '{4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};

    drive(4'b0000, 4'b0000, 32'h0, 1'b1, 1'b1);
    check("reset in_ready", in_ready0, 0);
    tick();
    check("reset out_valid", out_valid0, 0);
    check("reset out_data", out_data0, 0);
    check("reset out_last", out_last0, 0);
    check("reset out_chan", out_chan0, 0);
    $display("reset: out_valid=%b out_data=%h out_chan=%0d", out_valid0, out_data0, out_chan0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].ordy, 1'b0);
      check($sformatf("vec%0d in_ready", i), in_ready0, vecs[i].exp_ready);
      tick();
      check($sformatf("vec%0d out_valid", i), out_valid0, vecs[i].exp_ov);
      if (vecs[i].exp_ov) begin
        check($sformatf("vec%0d out_data", i), out_data0, vecs[i].exp_od);
        check($sformatf("vec%0d out_chan", i), out_chan0, vecs[i].exp_oc);
      end
      $display("vec %0d: in_ready=%b out_valid=%b out_data=%h out_chan=%0d",
               i, in_ready0, out_valid0, out_data0, out_chan0);
    end

    // Fixed priority: ch0 always beats ch3.
    drive(4'b0000, 4'b0000, 32'h0, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(4'b1001, 4'b1001, 32'h53000050, 1'b1, 1'b0);
      check("fixed in_ready", in_ready1, 4'b0001);
      tick();
      check("fixed out_valid", out_valid1, 1);
      check("fixed out_chan", out_chan1, 0);
      check("fixed out_data", out_data1, 8'h50);
      $display("fixed %0d: out_chan=%0d out_data=%h", i, out_chan1, out_data1);
    end

    // Reset in the middle of a locked ch2 packet.
    drive(4'b0000, 4'b0000, 32'h0, 1'b1, 1'b1);
    tick();
    drive(4'b0100, 4'b0000, 32'h00210000, 1'b1, 1'b0);
    tick();
    check("midrst beat1", out_data0, 8'h21);
    check("midrst chan1", out_chan0, 2);
    drive(4'b0100, 4'b0000, 32'h00220000, 1'b1, 1'b0);
    tick();
    check("midrst beat2", out_data0, 8'h22);
    drive(4'b0100, 4'b0000, 32'h00230000, 1'b1, 1'b1);
    check("midrst in_ready", in_ready0, 0);
    tick();
    check("midrst out_valid", out_valid0, 0);
    drive(4'b0101, 4'b0001, 32'h0023000A, 1'b1, 1'b0);
    check("postrst in_ready", in_ready0, 4'b0001);
    tick();
    check("postrst out_chan", out_chan0, 0);
    check("postrst out_data", out_data0, 8'h0A);
    $display("midrst: after reset out_chan=%0d out_data=%h", out_chan0, out_data0);

    // Locked on ch1 with bubbles while ch0 keeps requesting.
    drive(4'b0010, 4'b0000, 32'h00003100, 1'b1, 1'b0);
    check("bubble lock ready", in_ready0, 4'b0010);
    tick();
    check("bubble lock data", out_data0, 8'h31);
    for (int i = 0; i < 2; i++) begin
      drive(4'b0001, 4'b0001, 32'h0000000B, 1'b1, 1'b0);
      check("bubble in_ready", in_ready0, 0);
      tick();
      check("bubble out_valid", out_valid0, 0);
      $display("bubble %0d: in_ready=%b out_valid=%b", i, in_ready0, out_valid0);
    end
    drive(4'b0011, 4'b0001, 32'h0000320B, 1'b1, 1'b0);
    check("resume ready", in_ready0, 4'b0010);
    tick();
    check("resume data", out_data0, 8'h32);
    check("resume chan", out_chan0, 1);
    drive(4'b0011, 4'b0011, 32'h0000330B, 1'b1, 1'b0);
    check("resume last ready", in_ready0, 4'b0010);
    tick();
    check("resume last data", out_data0, 8'h33);
    drive(4'b0001, 4'b0001, 32'h0000000B, 1'b1, 1'b0);
    check("unlock ready", in_ready0, 4'b0001);
    tick();
    check("unlock data", out_data0, 8'h0B);
    $display("bubble: resumed and released, next out_chan=%0d", out_chan0);

    // Randomized traffic with backpressure and occasional reset.
    for (int i = 0; i < 500; i++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom & $urandom), $urandom,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
      if (|(in_ready0 & in_valid))
        $display("rnd %0d: accept ch%0d data=%h last=%b", i, $clog2(in_ready0),
                 in_data[$clog2(in_ready0)*W +: W], in_last[$clog2(in_ready0)]);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
